// File: rtl/dlsc_demosaic_vng_accum.sv
// Gradient-thresholded colour accumulator for the VNG demosaic pipeline.
// Sums the channels of every direction whose gradient passes the group threshold.
module dlsc_demosaic_vng_accum #(
  parameter int DATA     = 8,
  parameter int GRAD     = 11,
  parameter int CHANNELS = 3,
  parameter int DIRS     = 8,
  parameter int CNTB     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clk_en,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_last,
  input  logic [GRAD-1:0]                 in_grad,
  input  logic [GRAD-1:0]                 in_thresh,
  input  logic [CHANNELS*(DATA+1)-1:0]    in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CHANNELS*(DATA+1+CNTB)-1:0] out_sum,
  output logic [CNTB-1:0]                 out_cnt,
  output logic                            out_fallback,
  output logic                            out_overflow
);

  localparam int CW   = DATA + 1;
  localparam int SUMW = CW + CNTB;

  logic                   out_valid_reg;
  logic [CNTB-1:0]        out_cnt_reg;
  logic                   out_fallback_reg;
  logic                   out_overflow_reg;

  logic [CNTB-1:0]        cnt_reg;
  logic [CNTB-1:0]        idx_reg;
  logic                   first_reg;
  logic [GRAD-1:0]        thresh_reg;
  logic [GRAD-1:0]        min_grad_reg;
  logic [CHANNELS*CW-1:0] min_data_reg;
  logic                   ovf_reg;

  logic                   in_xfer;
  logic                   out_xfer;
  logic                   finish;
  logic [GRAD-1:0]        eff_thresh;
  logic                   pass;
  logic                   in_range;
  logic                   take;
  logic [CNTB-1:0]        cnt_next;
  logic                   min_load;
  logic [GRAD-1:0]        min_grad_next;
  logic [CHANNELS*CW-1:0] min_data_next;
  logic                   ovf_next;
  logic                   use_fallback;

  assign in_ready  = !out_valid_reg | out_ready;
  assign in_xfer   = clk_en & in_valid & in_ready;
  assign out_xfer  = clk_en & out_valid_reg & out_ready;
  assign finish    = in_xfer & in_last;

  assign eff_thresh = first_reg ? in_thresh : thresh_reg;
  assign pass       = (in_grad <= eff_thresh);
  assign in_range   = (idx_reg < CNTB'(DIRS));
  assign take       = pass & in_range;
  assign cnt_next   = cnt_reg + CNTB'(take);

  // Strict less-than so that equal gradients keep the earlier beat.
  assign min_load      = in_range & (first_reg | (in_grad < min_grad_reg));
  assign min_grad_next = min_load ? in_grad : min_grad_reg;
  assign min_data_next = min_load ? in_data : min_data_reg;
  assign ovf_next      = ovf_reg | !in_range;
  assign use_fallback  = (cnt_next == '0);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [CW-1:0]   ch;
      logic [CW-1:0]   min_ch;
      logic [SUMW-1:0] acc_reg;
      logic [SUMW-1:0] acc_next;
      logic [SUMW-1:0] sum_reg;

      assign ch       = in_data[gi*CW +: CW];
      assign min_ch   = min_data_next[gi*CW +: CW];
      assign acc_next = acc_reg + (take ? SUMW'(ch) : '0);

      always_ff @(posedge clk) begin
        if (rst) begin
          acc_reg <= '0;
          sum_reg <= '0;
        end else if (in_xfer) begin
          if (in_last) begin
            acc_reg <= '0;
            sum_reg <= use_fallback ? SUMW'(min_ch) : acc_next;
          end else begin
            acc_reg <= acc_next;
          end
        end
      end

      assign out_sum[gi*SUMW +: SUMW] = sum_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg    <= 1'b0;
      out_cnt_reg      <= '0;
      out_fallback_reg <= 1'b0;
      out_overflow_reg <= 1'b0;
      cnt_reg          <= '0;
      idx_reg          <= '0;
      first_reg        <= 1'b1;
      thresh_reg       <= '0;
      min_grad_reg     <= '0;
      min_data_reg     <= '0;
      ovf_reg          <= 1'b0;
    end else begin
      if (finish) begin
        out_valid_reg <= 1'b1;
      end else if (out_xfer) begin
        out_valid_reg <= 1'b0;
      end

      if (in_xfer) begin
        if (in_last) begin
          out_cnt_reg      <= use_fallback ? CNTB'(1) : cnt_next;
          out_fallback_reg <= use_fallback;
          out_overflow_reg <= ovf_next;
          cnt_reg          <= '0;
          idx_reg          <= '0;
          first_reg        <= 1'b1;
          min_grad_reg     <= '0;
          min_data_reg     <= '0;
          ovf_reg          <= 1'b0;
        end else begin
          cnt_reg      <= cnt_next;
          idx_reg      <= in_range ? idx_reg + CNTB'(1) : idx_reg;
          first_reg    <= 1'b0;
          thresh_reg   <= eff_thresh;
          min_grad_reg <= min_grad_next;
          min_data_reg <= min_data_next;
          ovf_reg      <= ovf_next;
        end
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_cnt      = out_cnt_reg;
  assign out_fallback = out_fallback_reg;
  assign out_overflow = out_overflow_reg;

endmodule

// File: doc/dlsc_demosaic_vng_accum.md
Name: dlsc_demosaic_vng_accum

Overview:
- Generic gradient-thresholded colour accumulator for the VNG demosaic pipeline.
- Consumes a serial stream of per-direction samples: a gradient plus CHANNELS colour values per beat, grouped by in_last.
- Sums the colour values of every direction whose gradient is <= the group threshold, counts the passing directions, and emits one result per group.
- Generalises the fixed 3-colour, two-slice summer: channel count, direction count and width are parametrised, with ready/valid backpressure, a minimum-gradient fallback and overflow detection.

Parameters:
- DATA, 8: base pixel width; each channel input is DATA+1 bits.
- GRAD, 11: gradient and threshold width.
- CHANNELS, 3: colour channels per beat (>=1).
- DIRS, 8: maximum directions per group (2..15).
- CNTB, 4: count width; must satisfy 2^CNTB > DIRS.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- clk_en  in  1  global enable; when low, all state is frozen and no transfer occurs.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_last  in  1  final direction of the group.
- in_grad  in  GRAD  gradient of this direction.
- in_thresh  in  GRAD  group threshold; sampled on the first beat of a group only.
- in_data  in  CHANNELS*(DATA+1)  channel values, channel 0 in the LSBs.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  CHANNELS*(DATA+1+CNTB)  per-channel sums, channel 0 in the LSBs.
- out_cnt  out  CNTB  number of directions contributing to out_sum.
- out_fallback  out  1  result came from the minimum-gradient fallback.
- out_overflow  out  1  the group had more than DIRS beats.

Behaviour:
- Transfer rules:
  - in_xfer = clk_en & in_valid & in_ready.
  - out_xfer = clk_en & out_valid & out_ready.
  - in_ready = !out_valid | out_ready (combinational). The block stalls only while a result is held.
- Reset: out_valid=0, out_sum=0, out_cnt=0, out_fallback=0, out_overflow=0. The internal accumulators, count, beat index, first-beat flag (set to 1) and min-gradient tracker are all cleared. Reset overrides clk_en and discards any partial group.
- Per in_xfer beat:
  - Effective threshold is in_thresh on the first beat, otherwise the registered threshold. The first-beat flag clears after the beat and sets again after each in_last.
  - pass = (in_grad <= effective threshold), unsigned compare.
  - If pass and beat index < DIRS: add each channel (zero-extended) to its accumulator and increment the count.
  - Track the minimum in_grad and its in_data. Ties keep the earlier beat. The first beat always loads the tracker.
  - Beat index increments, saturating at DIRS. A beat arriving with index == DIRS sets a sticky overflow flag and is otherwise ignored: no accumulate, no min update.
- On an in_xfer with in_last (the final beat's own contribution is included):
  - If count including this beat > 0: out_sum = accumulators, out_cnt = count, out_fallback = 0.
  - Else: out_sum = the min-gradient beat's channels, out_cnt = 1, out_fallback = 1.
  - out_overflow = sticky flag. out_valid is set on the next clock edge (latency 1 cycle from the last beat).
  - The accumulators, count, index, tracker and sticky flag clear for the next group. A new group's first beat may arrive in the cycle right after the last beat if in_ready allows.
- Output handshake:
  - out_xfer without a new result clears out_valid.
  - out_xfer and a completing in_last in the same cycle: the new result loads and out_valid stays 1 (back-to-back single-beat groups run at full rate).
  - out_sum, out_cnt and the flags stay stable while out_valid & !out_ready.
- Widths: the sums cannot overflow, since DIRS*(2^(DATA+1)-1) < 2^(DATA+1+CNTB). No saturation logic is required.
- clk_en low mid-group: the partial state is held. in_ready still reflects out_valid/out_ready, but no transfer occurs.
- Single-beat group (first beat with in_last): threshold, accumulate and finalise all happen in the same cycle.

Test Plan:
(DATA=8, CHANNELS=3, DIRS=8 unless stated.)
1. Basic sum: group of 8 beats, thresh=10, grads {3,12,10,0,11,20,5,10}, each beat's channels = {beat, beat+1, beat+2} (beat numbered 1..8).
   -> Passing beats are 1,3,4,7,8; out_cnt=5; out_sum ch0=23, ch1=28, ch2=33; fallback=0; out_valid 1 cycle after the last beat.
2. Fallback: 4 beats, thresh=2, grads {9,4,4,7}.
   -> out_cnt=1, fallback=1, out_sum = beat 2's channels (earliest tie wins).
3. Overflow: 10 beats, all grad=0 and channels=255, last on beat 10.
   -> out_cnt=8, ch sums=2040, out_overflow=1; the next group reports overflow=0.
4. Backpressure: out_ready=0 when a result completes.
   -> in_ready=0 and the next group's first beat is not accepted. Raise out_ready for one cycle -> the result pops, in_ready=1, and the second result matches an independent model.
5. Threshold sampling: thresh changes 5 -> 0 mid-group, grads all 3, 3 beats.
   -> out_cnt=3, since the first-beat threshold 5 holds for the whole group.
6. Reset and clk_en: rst mid-group after 2 beats -> all outputs 0 and the next group's result excludes the old beats. clk_en low for 3 cycles mid-group -> the result is identical to the ungated run.
